// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Round-robin Wishbone B3 arbiter sharing one slave port between NUM_MASTERS
// master ports. Ownership lasts for the whole bus cycle (CYC high), so classic
// cycles and CTI/BTE bursts pass through atomically. Master-side buses are
// flattened vectors, with master i occupying slice i.
//
// Parameters
//   NUM_MASTERS  number of master ports (2..16)
//   aw           address width
//   dw           data width (multiple of 8)
//
// Ports
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   wbm_*_i                    flattened master requests (adr/dat/sel/we/cyc/stb/cti/bte)
//   wbm_dat_o                  slave read data replicated onto every slice
//   wbm_ack_o/err_o/rty_o      slave responses routed to the owning master only
//   wbs_*_o                    slave-side request, muxed from the owning master
//   wbs_dat_i/ack_i/err_i/rty_i slave responses
//   grant_o                    one-hot registered grant, zero when idle
//   busy_o                     high while any master owns the bus
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int aw          = 32,
    parameter int dw          = 32
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,

    input  logic [NUM_MASTERS*aw-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*dw-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*dw/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [NUM_MASTERS*dw-1:0]   wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,

    output logic [aw-1:0]               wbs_adr_o,
    output logic [dw-1:0]               wbs_dat_o,
    output logic [dw/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [dw-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,

    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        busy_o
);

    localparam int LW = $clog2(NUM_MASTERS);
    localparam int SW = dw / 8;

    // -------------------------------------------------------------------------
    // Arbitration state
    // -------------------------------------------------------------------------
    logic [NUM_MASTERS-1:0] grant_reg;
    logic [NUM_MASTERS-1:0] grant_next;
    logic [LW-1:0]          last_reg;
    logic [LW-1:0]          last_next;
    logic                   arb_edge;

    // The bus is up for grabs when nobody owns it or the owner has released
    // CYC. Because grant is one-hot, both cases reduce to "no granted master
    // is holding CYC".
    assign arb_edge = ~|(grant_reg & wbm_cyc_i);

    // Rotating-priority search: start just after the last winner and wrap,
    // so the previous owner is only re-granted when nobody else is asking.
    always_comb begin
        int   idx;
        logic found;
        grant_next = grant_reg;
        last_next  = last_reg;
        idx        = 0;
        found      = 1'b0;
        if (arb_edge) begin
            grant_next = '0;
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                idx = (int'(last_reg) + k) % NUM_MASTERS;
                if (!found && wbm_cyc_i[idx]) begin
                    found           = 1'b1;
                    grant_next[idx] = 1'b1;
                    last_next       = LW'(idx);
                end
            end
        end
    end

    // Reset leaves last at the top index so master 0 is first in line.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            grant_reg <= '0;
            last_reg  <= LW'(NUM_MASTERS - 1);
        end else begin
            grant_reg <= grant_next;
            last_reg  <= last_next;
        end
    end

    assign grant_o = grant_reg;
    assign busy_o  = |grant_reg;

    // -------------------------------------------------------------------------
    // Slave-side mux: each slice is masked by its grant bit and the masked
    // slices are OR-ed together. With a one-hot (or zero) grant this selects
    // the owner, and everything reads zero when idle or in reset.
    // -------------------------------------------------------------------------
    logic [aw-1:0]          adr_m [NUM_MASTERS];
    logic [dw-1:0]          dat_m [NUM_MASTERS];
    logic [SW-1:0]          sel_m [NUM_MASTERS];
    logic [2:0]             cti_m [NUM_MASTERS];
    logic [1:0]             bte_m [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] we_m;
    logic [NUM_MASTERS-1:0] cyc_m;
    logic [NUM_MASTERS-1:0] stb_m;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
            assign adr_m[gi] = grant_reg[gi] ? wbm_adr_i[gi*aw +: aw] : '0;
            assign dat_m[gi] = grant_reg[gi] ? wbm_dat_i[gi*dw +: dw] : '0;
            assign sel_m[gi] = grant_reg[gi] ? wbm_sel_i[gi*SW +: SW] : '0;
            assign cti_m[gi] = grant_reg[gi] ? wbm_cti_i[gi*3 +: 3]   : 3'b000;
            assign bte_m[gi] = grant_reg[gi] ? wbm_bte_i[gi*2 +: 2]   : 2'b00;
            assign we_m[gi]  = grant_reg[gi] & wbm_we_i[gi];

            // CYC is qualified live so an owner dropping CYC mid-cycle is
            // seen by the slave in the same cycle, not one edge later.
            assign cyc_m[gi] = grant_reg[gi] & wbm_cyc_i[gi];
            assign stb_m[gi] = cyc_m[gi] & wbm_stb_i[gi];

            // Responses reach only the owner, and only while its cycle is live,
            // so stray slave responses during idle are swallowed.
            assign wbm_ack_o[gi] = cyc_m[gi] & wbs_ack_i;
            assign wbm_err_o[gi] = cyc_m[gi] & wbs_err_i;
            assign wbm_rty_o[gi] = cyc_m[gi] & wbs_rty_i;

            assign wbm_dat_o[gi*dw +: dw] = wbs_dat_i;
        end
    endgenerate

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_cti_o = 3'b000;
        wbs_bte_o = 2'b00;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            wbs_adr_o = wbs_adr_o | adr_m[m];
            wbs_dat_o = wbs_dat_o | dat_m[m];
            wbs_sel_o = wbs_sel_o | sel_m[m];
            wbs_cti_o = wbs_cti_o | cti_m[m];
            wbs_bte_o = wbs_bte_o | bte_m[m];
        end
    end

    assign wbs_we_o  = |we_m;
    assign wbs_cyc_o = |cyc_m;
    assign wbs_stb_o = |stb_m;

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone B3 arbiter that shares one slave port between NUM_MASTERS master ports.
- Typical masters are wb_bfm_master instances or DMA engines; the slave is an interconnect or memory.
- Grant is held for the whole bus cycle (CYC high), so classic cycles and incrementing/constant bursts (CTI/BTE) pass through atomically.
- Master-side buses are flattened vectors, with master i occupying slice i.

Parameters:
- NUM_MASTERS, 2: number of master ports, range 2..16.
- aw, 32: address width.
- dw, 32: data width, a multiple of 8.

Ports:
- wb_clk_i  in  1  clock; all state updates on the rising edge.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- wbm_adr_i  in  NUM_MASTERS*aw  master addresses.
- wbm_dat_i  in  NUM_MASTERS*dw  master write data.
- wbm_sel_i  in  NUM_MASTERS*dw/8  byte selects.
- wbm_we_i  in  NUM_MASTERS  write enables.
- wbm_cyc_i  in  NUM_MASTERS  cycle requests.
- wbm_stb_i  in  NUM_MASTERS  strobes.
- wbm_cti_i  in  NUM_MASTERS*3  cycle type identifiers.
- wbm_bte_i  in  NUM_MASTERS*2  burst type extensions.
- wbm_dat_o  out  NUM_MASTERS*dw  read data, a copy of wbs_dat_i on every slice.
- wbm_ack_o  out  NUM_MASTERS  ack, routed to the granted master only.
- wbm_err_o  out  NUM_MASTERS  err, routed to the granted master only.
- wbm_rty_o  out  NUM_MASTERS  rty, routed to the granted master only.
- wbs_adr_o  out  aw  slave address.
- wbs_dat_o  out  dw  slave write data.
- wbs_sel_o  out  dw/8  slave byte selects.
- wbs_we_o  out  1  slave write enable.
- wbs_cyc_o  out  1  slave cycle.
- wbs_stb_o  out  1  slave strobe.
- wbs_cti_o  out  3  slave cycle type.
- wbs_bte_o  out  2  slave burst type.
- wbs_dat_i  in  dw  slave read data.
- wbs_ack_i  in  1  slave ack.
- wbs_err_i  in  1  slave err.
- wbs_rty_i  in  1  slave rty.
- grant_o  out  NUM_MASTERS  one-hot registered grant; all zero when idle.
- busy_o  out  1  OR of grant_o.

Behaviour:
- State registers:
  - grant: one-hot, NUM_MASTERS bits.
  - last: index of the most recently granted master, $clog2(NUM_MASTERS) bits.
- Reset (wb_rst_ni low, asynchronous):
  - grant cleared to 0; last set to NUM_MASTERS-1, so master 0 has highest priority after reset.
  - All wbs_* outputs are 0.
  - wbm_ack_o, wbm_err_o and wbm_rty_o are 0.
- States:
  - IDLE: grant==0.
  - OWNED(i): grant[i]==1.
- Arbitration edge: any rising edge where the state is IDLE, or OWNED(i) with wbm_cyc_i[i]==0.
- On an arbitration edge:
  - Search wbm_cyc_i for the first set bit, starting at (last+1) mod NUM_MASTERS and wrapping.
  - If found at j: grant becomes one-hot j, last becomes j.
  - Otherwise: grant becomes 0 and last is unchanged.
  - When released from OWNED(i), a new winner can be granted on the same edge. There are no idle bubbles between back-to-back owners.
  - i is re-granted only if no other master is requesting.
- Non-arbitration edges: grant is held.
  - No preemption: a granted master keeps the bus regardless of other requests, and regardless of STB, ACK, ERR or RTY.
- Latency: a request whose CYC rises before edge N is seen on wbs_cyc_o after edge N, if the bus is free. Minimum 1 cycle.
- Slave mux (combinational from grant):
  - wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o and wbs_bte_o come from the granted slice; all 0 when idle.
  - wbs_cyc_o = OR over i of grant[i] & wbm_cyc_i[i].
  - wbs_stb_o = OR over i of grant[i] & wbm_cyc_i[i] & wbm_stb_i[i].
  - If the owner drops CYC mid-cycle, wbs_cyc_o and wbs_stb_o fall in the same cycle.
- Response routing:
  - wbm_ack_o[i] = grant[i] & wbm_cyc_i[i] & wbs_ack_i; err and rty follow the same rule.
  - Ungranted masters never see a response, even if the slave asserts one spuriously while idle.
- Bursts: CTI and BTE pass through unchanged. The arbiter does not inspect CTI; end of ownership is solely the CYC deassert.
- Simultaneous requests: resolved purely by the rotating pointer. With all masters requesting continuously, grants rotate 0,1,...,N-1,0.
- Reset mid-cycle: grant is cleared immediately and the slave sees CYC fall asynchronously. Masters must restart their cycles.

Test Plan:
- Reset with NUM_MASTERS=3 and all cyc low -> grant_o=000, wbs_cyc_o=0, all wbm_ack_o=0.
- Masters 0 and 2 raise cyc on the same edge -> master 0 granted (grant_o=001). After it drops cyc, master 2 is granted on that same edge with no bubble. A classic write of 0xDEADBEEF to 0x100 from master 2 reaches wbs_dat_o/wbs_adr_o; only wbm_ack_o[2] pulses.
- All 3 masters hold cyc high and each performs one single-beat cycle per ownership -> grant sequence 0,1,2,0,1,2.
- Master 1 issues an 8-beat incrementing burst (cti 010 then 111, bte 00) while master 0 requests -> master 0 stays ungranted until master 1 drops cyc. Slave sees 8 contiguous beats; wbm_ack_o[0] stays 0 throughout.
- Slave pulses wbs_err_i during master 2's cycle -> wbm_err_o=100. Slave pulses ack while idle -> no wbm_ack_o asserted.
- wb_rst_ni pulsed low mid-burst by master 1 -> grant_o=000 and wbs_cyc_o=0 immediately. After release, master 0 wins if both 0 and 1 request.
